// File: rtl/ofdm_fft_pkg.sv
// ofdm_fft_pkg: shared widths, FSM states and fixed-point constants for the FFT/IFFT datapath
package ofdm_fft_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, CALC, DRAIN} state_t;
  localparam int FLT_BIT_DEF = 6;
  localparam int ONE = 1 << FLT_BIT_DEF;
  function automatic int dw_f(int s, int i, int f);
    return s + i + f;
  endfunction
  function automatic int ow_f(int s, int i, int f);
    return dw_f(s, i, f) + 2;
  endfunction
endpackage

// File: rtl/ibf4_comb.sv
// ibf4_comb: combinational radix-4 inverse butterfly; xr/xi = x1..x4 (DW), yr/yi = y1..y4 (OW), optional >>>2 when SCALE=1
module ibf4_comb
  import ofdm_fft_pkg::*;
#(
  parameter int DW = 13,
  parameter int OW = 15,
  parameter int SCALE = 0
) (
  input  logic signed [DW-1:0] xr [4],
  input  logic signed [DW-1:0] xi [4],
  output logic signed [OW-1:0] yr [4],
  output logic signed [OW-1:0] yi [4]
);
  logic signed [OW-1:0] a [4];
  logic signed [OW-1:0] b [4];
  logic signed [OW-1:0] sr [4];
  logic signed [OW-1:0] si [4];
  assign sr[0] = a[0] + a[1] + a[2] + a[3];
  assign si[0] = b[0] + b[1] + b[2] + b[3];
  assign sr[1] = a[0] - b[1] - a[2] + b[3];
  assign si[1] = b[0] + a[1] - b[2] - a[3];
  assign sr[2] = a[0] - a[1] + a[2] - a[3];
  assign si[2] = b[0] - b[1] + b[2] - b[3];
  assign sr[3] = a[0] + b[1] - a[2] - b[3];
  assign si[3] = b[0] - a[1] - b[2] + a[3];
  genvar g;
  for (g = 0; g < 4; g++) begin : g_lane
    assign a[g] = OW'(xr[g]);
    assign b[g] = OW'(xi[g]);
    assign yr[g] = (SCALE != 0) ? sr[g] >>> 2 : sr[g];
    assign yi[g] = (SCALE != 0) ? si[g] >>> 2 : si[g];
  end
endmodule

// File: rtl/ibf4_stream.sv
// ibf4_stream: streaming radix-4 IDFT; in_valid/in_ready/in_sof/in_re/in_im collect x1..x4, out_valid/out_ready/out_re/out_im/out_idx/out_last emit y1..y4
module ibf4_stream
  import ofdm_fft_pkg::*;
#(
  parameter int SIGN_BIT = 1,
  parameter int INT_BIT = 6,
  parameter int FLT_BIT = 6,
  parameter int SCALE = 0,
  localparam int DW = dw_f(SIGN_BIT, INT_BIT, FLT_BIT),
  localparam int OW = ow_f(SIGN_BIT, INT_BIT, FLT_BIT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_re,
  output logic signed [OW-1:0] out_im,
  output logic [1:0]           out_idx,
  output logic                 out_last
);
  state_t state, nxt;
  logic [1:0] in_cnt, out_cnt, widx;
  logic in_acc, out_acc;
  logic signed [DW-1:0] xr [4];
  logic signed [DW-1:0] xi [4];
  logic signed [OW-1:0] yr [4];
  logic signed [OW-1:0] yi [4];
  logic signed [OW-1:0] rr [4];
  logic signed [OW-1:0] ri [4];
  assign in_acc = in_valid && in_ready;
  assign out_acc = out_valid && out_ready;
  // an accepted sof always restarts the frame at x1, dropping any partial frame
  assign widx = in_sof ? 2'd0 : in_cnt;
  ibf4_comb #(.DW(DW), .OW(OW), .SCALE(SCALE)) u_comb (
    .xr(xr),
    .xi(xi),
    .yr(yr),
    .yi(yi)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state == IDLE ? LOAD :
          state == LOAD ? ((in_acc && !in_sof && in_cnt == 2'd3) ? CALC : LOAD) :
          state == CALC ? DRAIN :
          ((out_acc && out_cnt == 2'd3) ? LOAD : DRAIN);
  end
  always_comb begin
    in_ready = state == LOAD;
    out_valid = state == DRAIN;
    out_re = rr[out_cnt];
    out_im = ri[out_cnt];
    out_idx = out_cnt;
    out_last = out_valid && out_cnt == 2'd3;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt <= '0;
      out_cnt <= '0;
      xr <= '{default: '0};
      xi <= '{default: '0};
      rr <= '{default: '0};
      ri <= '{default: '0};
    end else begin
      if (in_acc) begin
        xr[widx] <= in_re;
        xi[widx] <= in_im;
        in_cnt <= widx + 2'd1;
      end
      if (state == CALC) begin
        rr <= yr;
        ri <= yi;
      end
      if (out_acc) out_cnt <= out_cnt + 2'd1;
    end
  end
endmodule
